// File: rtl/cmp_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_arbiter_if                                             |
// | Description : Bundle for the shared-comparator scheduler. Requesters     |
// |               drive req/op_a/op_b; the arbiter returns a one-hot grant,  |
// |               busy, and the tagged compare result.                       |
// |   req       NREQ    level request per requester                          |
// |   op_a/op_b NREQ*W  operand pairs, requester i at [i*W +: W]             |
// |   gnt       NREQ    one-hot grant, one cycle                             |
// |   busy      1       arbiter not idle                                     |
// |   rsp_*             result strobe, requester id, ne/le/mo flags          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cmp_arbiter_if #(
  parameter int LOGREQ   = 2,
  parameter int LOGWIDTH = 4
) ();
  localparam int NREQ = 2 ** LOGREQ;
  localparam int W    = 2 ** LOGWIDTH;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic [LOGREQ-1:0] rsp_id;
  logic              rsp_ne;
  logic              rsp_le;
  logic              rsp_mo;

  // Requester side.
  modport master (
    output req, op_a, op_b,
    input  gnt, busy, rsp_valid, rsp_id, rsp_ne, rsp_le, rsp_mo
  );

  // Arbiter side.
  modport slave (
    input  req, op_a, op_b,
    output gnt, busy, rsp_valid, rsp_id, rsp_ne, rsp_le, rsp_mo
  );
endinterface
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cmp_arbiter                                                |
// | Description : Round-robin scheduler for one shared unsigned comparator.  |
// |               IDLE picks a requester and captures its operands, EXEC     |
// |               compares the registered operands, RESP presents the        |
// |               flags tagged with the requester id.                        |
// |   clk    in  rising-edge clock                                           |
// |   reset  in  asynchronous active-high reset                              |
// |   bus    slave modport of cmp_arbiter_if                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cmp_arbiter #(
  parameter int LOGREQ   = 2,
  parameter int LOGWIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  cmp_arbiter_if.slave  bus
);
  localparam int NREQ = 2 ** LOGREQ;
  localparam int W    = 2 ** LOGWIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [NREQ-1:0]   gnt_q,       gnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [LOGREQ-1:0] rsp_id_q,    rsp_id_d;
  logic              rsp_ne_q,    rsp_ne_d;
  logic              rsp_le_q,    rsp_le_d;
  logic              rsp_mo_q,    rsp_mo_d;
  logic [W-1:0]      opa_q,       opa_d;
  logic [W-1:0]      opb_q,       opb_d;
  logic [LOGREQ-1:0] last_id_q,   last_id_d;

  // Shared compare unit, fed only from the captured operands.
  logic cmp_ne, cmp_le, cmp_mo;
  always_comb begin
    cmp_ne = (opa_q != opb_q);
    cmp_le = (opa_q <  opb_q);
    cmp_mo = (opa_q >  opb_q);
  end

  // Round-robin search starting one past the last winner. Offset NREQ wraps
  // to last_id itself, so a lone requester is always found.
  logic              found;
  logic [LOGREQ-1:0] cand;
  logic [LOGREQ-1:0] winner;
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    winner = last_id_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last_id_q + LOGREQ'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_ne_d    = rsp_ne_q;
    rsp_le_d    = rsp_le_q;
    rsp_mo_d    = rsp_mo_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    last_id_d   = last_id_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          opa_d          = bus.op_a[winner*W +: W];
          opb_d          = bus.op_b[winner*W +: W];
          gnt_d[winner]  = 1'b1;
          rsp_id_d       = winner;
          last_id_d      = winner;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_ne_d    = cmp_ne;
        rsp_le_d    = cmp_le;
        rsp_mo_d    = cmp_mo;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_ne_q    <= 1'b0;
      rsp_le_q    <= 1'b0;
      rsp_mo_q    <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      last_id_q   <= LOGREQ'(NREQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ne_q    <= rsp_ne_d;
      rsp_le_q    <= rsp_le_d;
      rsp_mo_q    <= rsp_mo_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      last_id_q   <= last_id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ne    = rsp_ne_q;
  assign bus.rsp_le    = rsp_le_q;
  assign bus.rsp_mo    = rsp_mo_q;
endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cmp_arbiter                                             |
// | Description : Directed self-checking bench for cmp_arbiter (NREQ=4,      |
// |               W=16) with hand-computed expectations.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cmp_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cmp_arbiter_if #(.LOGREQ(2), .LOGWIDTH(4)) bus ();

  cmp_arbiter #(.LOGREQ(2), .LOGWIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {ne, le, mo}.
  function automatic logic [31:0] flags();
    return {29'd0, bus.rsp_ne, bus.rsp_le, bus.rsp_mo};
  endfunction

  logic [2:0] rr_flags [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rr_flags    = '{3'b110, 3'b000, 3'b101, 3'b101};
    reset       = 1'b1;
    bus.req     = '0;
    bus.op_a    = '0;
    bus.op_b    = '0;

    // Reset state.
    tick(); tick();
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_id",    32'(bus.rsp_id), 32'h0);
    chk("rst_flags", flags(), 32'h0);
    reset = 1'b0;

    // Single request from requester 1: 0x1234 < 0x1235.
    bus.req = 4'b0010;
    bus.op_a[16 +: 16] = 16'h1234;
    bus.op_b[16 +: 16] = 16'h1235;
    tick();
    chk("s1_gnt",  32'(bus.gnt), 32'h2);
    chk("s1_busy", 32'(bus.busy), 32'h1);
    chk("s1_val0", 32'(bus.rsp_valid), 32'h0);
    bus.req = '0;
    tick();
    chk("s1_gnt_off", 32'(bus.gnt), 32'h0);
    chk("s1_valid",   32'(bus.rsp_valid), 32'h1);
    chk("s1_id",      32'(bus.rsp_id), 32'h1);
    chk("s1_flags",   flags(), 32'h6);
    chk("s1_busy2",   32'(bus.busy), 32'h1);
    tick();
    chk("s1_val_off", 32'(bus.rsp_valid), 32'h0);
    chk("s1_idle",    32'(bus.busy), 32'h0);
    chk("s1_id_hold", 32'(bus.rsp_id), 32'h1);

    // Equal operands on requester 0.
    bus.req = 4'b0001;
    bus.op_a[0 +: 16] = 16'hABCD;
    bus.op_b[0 +: 16] = 16'hABCD;
    tick();
    chk("eq_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    chk("eq_id",    32'(bus.rsp_id), 32'h0);
    chk("eq_flags", flags(), 32'h0);
    tick();

    // Unsigned extreme: 0xFFFF > 0x0000.
    bus.req = 4'b0001;
    bus.op_a[0 +: 16] = 16'hFFFF;
    bus.op_b[0 +: 16] = 16'h0000;
    tick();
    chk("max_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    chk("max_flags", flags(), 32'h5);
    tick();

    // Fresh reset so the round-robin pointer restarts at requester 0.
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Round robin with all four requesting continuously.
    bus.op_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    bus.op_b = {4{16'h0002}};
    bus.req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr%0d_gnt", i), 32'(bus.gnt), 32'(4'b0001 << (i % 4)));
      tick();
      chk($sformatf("rr%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
      chk($sformatf("rr%0d_id", i),    32'(bus.rsp_id), 32'(i % 4));
      chk($sformatf("rr%0d_flags", i), flags(), 32'(rr_flags[i % 4]));
      tick();
      chk($sformatf("rr%0d_idle", i), 32'(bus.busy), 32'h0);
    end
    bus.req = '0;

    // Wrap-around skip: grant 2, then req=0011 searches 3,0 -> 0, then 1.
    bus.req = 4'b0100;
    tick();
    chk("wr_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick(); tick();
    bus.req = 4'b0011;
    tick();
    chk("wr_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0010;
    tick(); tick();
    tick();
    chk("wr_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    tick();
    chk("wr_id1", 32'(bus.rsp_id), 32'h1);
    tick();

    // Reset during EXEC: outputs clear without a clock edge.
    bus.req = 4'b0100;
    tick();
    chk("mr_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    #2;
    reset = 1'b1;
    #1;
    chk("mr_gnt_clr",   32'(bus.gnt), 32'h0);
    chk("mr_busy_clr",  32'(bus.busy), 32'h0);
    chk("mr_valid_clr", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("mr_no_valid", 32'(bus.rsp_valid), 32'h0);
    reset = 1'b0;
    tick();
    chk("mr_no_valid2", 32'(bus.rsp_valid), 32'h0);
    bus.req = 4'b1100;
    tick();
    chk("mr_regnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();
    chk("mr_id", 32'(bus.rsp_id), 32'h2);
    tick();

    // Late request and operand change during EXEC do not disturb the result.
    bus.req = 4'b0001;
    bus.op_a[0 +: 16] = 16'h0010;
    bus.op_b[0 +: 16] = 16'h0020;
    tick();
    chk("lt_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1000;
    bus.op_a[0 +: 16] = 16'h0030;
    tick();
    chk("lt_gnt_off", 32'(bus.gnt), 32'h0);
    chk("lt_id",      32'(bus.rsp_id), 32'h0);
    chk("lt_flags",   flags(), 32'h6);
    tick();
    chk("lt_no_gnt", 32'(bus.gnt), 32'h0);
    tick();
    chk("lt_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    tick();
    chk("lt_id3", 32'(bus.rsp_id), 32'h3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
